// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues registered bus transactions for loads/stores,
// stalls the pipeline until completion and selects the write-back value. Optional: MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_stop_i,
  input  logic [1:0]  mem_reg_write_i,
  input  logic [1:0]  mem_mem_write_i,
  input  logic        mem_mem_read_i,
  input  logic        mem_reg_we_i,
  input  logic [31:0] mem_resC_i,
  input  logic [31:0] mem_rD2_i,
  input  logic [31:0] mem_ext_i,
  input  logic [31:0] mem_pc4_i,
  input  logic [4:0]  mem_wR_i,
  input  logic        mem_debug_wb_have_inst_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [3:0]  dbus_wstrb_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        pipeline_stop_o,
  output logic [31:0] wb_wd_o,
  output logic [4:0]  wb_wR_o,
  output logic        wb_reg_we_o,
  output logic        wb_debug_have_inst_o,
`ifdef MEM_TIMEOUT_EN
  output logic        err_o,
`endif
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic        is_store_s;
  logic        is_load_s;
  logic        access_s;
  logic        misalign_s;
  logic        aligned_access_s;
  logic        mis_access_s;
  logic        advance_s;
  logic        issue_s;
  logic        ack_s;
  logic        timeout_s;
  logic        tmo_hit_s;

  logic        done_flag_r;
  logic [31:0] load_q_r;
  logic        misalign_r;
  logic        mis_seen_r;
  logic        req_r;
  logic        we_r;
  logic [3:0]  wstrb_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  function automatic logic [3:0] lane_strb(input logic [1:0] mw, input logic [1:0] lo);
    logic [3:0] s;
    case (mw)
      2'b01:   s = 4'b1111;
      2'b10:   s = lo[1] ? 4'b1100 : 4'b0011;
      2'b11:   s = 4'b0001 << lo;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] mw, input logic [31:0] d);
    logic [31:0] w;
    case (mw)
      2'b01:   w = d;
      2'b10:   w = {2{d[15:0]}};
      2'b11:   w = {4{d[7:0]}};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Access decode and alignment check; a store wins over a simultaneous load.
  always_comb begin
    is_store_s = (mem_mem_write_i != 2'b00);
    is_load_s  = mem_mem_read_i & ~is_store_s;
    access_s   = is_store_s | mem_mem_read_i;
    case (mem_mem_write_i)
      2'b01:   misalign_s = (mem_resC_i[1:0] != 2'b00);
      2'b10:   misalign_s = mem_resC_i[0];
      2'b11:   misalign_s = 1'b0;
      default: misalign_s = mem_mem_read_i & (mem_resC_i[1:0] != 2'b00);
    endcase
    aligned_access_s = access_s & ~misalign_s;
    mis_access_s     = access_s & misalign_s;
  end

  assign pipeline_stop_o = aligned_access_s & ~done_flag_r;
  assign advance_s       = ~pipeline_stop_o & ~pipeline_stop_i;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_r;
  logic       err_r;

  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
  assign err_o     = err_r;

  // Bus wait counter (cleared on issue) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= 8'd0;
      err_r     <= 1'b0;
    end else begin
      if (issue_s) begin
        tmo_cnt_r <= 8'd0;
      end else if (state_r == ST_BUSY) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state logic and transaction events.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    ack_s        = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (aligned_access_s && !done_flag_r) begin
          state_next_s = ST_BUSY;
          issue_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dbus_ack_i) begin
          state_next_s = ST_DONE;
          ack_s        = 1'b1;
        end else if (tmo_hit_s) begin
          state_next_s = ST_DONE;
          timeout_s    = 1'b1;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (!pipeline_stop_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bus request fields: captured at issue, held through BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      wstrb_r <= 4'b0000;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else if (issue_s) begin
      req_r   <= 1'b1;
      we_r    <= is_store_s;
      wstrb_r <= lane_strb(mem_mem_write_i, mem_resC_i[1:0]);
      addr_r  <= {mem_resC_i[31:2], 2'b00};
      wdata_r <= lane_wdata(mem_mem_write_i, mem_rD2_i);
    end else if (ack_s || timeout_s) begin
      req_r   <= 1'b0;
    end
  end

  // Completion bookkeeping: load data, done flag, misalignment pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q_r    <= 32'h0000_0000;
      done_flag_r <= 1'b0;
      misalign_r  <= 1'b0;
      mis_seen_r  <= 1'b0;
    end else begin
      if (ack_s) begin
        load_q_r <= dbus_rdata_i;
      end else if (timeout_s) begin
        load_q_r <= 32'h0000_0000;
      end
      if (ack_s || timeout_s) begin
        done_flag_r <= 1'b1;
      end else if (advance_s) begin
        done_flag_r <= 1'b0;
      end
      // A misaligned instruction held by a downstream stall reports only once.
      misalign_r <= mis_access_s & ~mis_seen_r;
      mis_seen_r <= mis_access_s & pipeline_stop_i;
    end
  end

  // Write-back data select.
  always_comb begin
    case (mem_reg_write_i)
      2'b00:   wb_wd_o = mem_resC_i;
      2'b01:   wb_wd_o = load_q_r;
      2'b10:   wb_wd_o = mem_ext_i;
      2'b11:   wb_wd_o = mem_pc4_i;
      default: wb_wd_o = mem_resC_i;
    endcase
  end

  assign dbus_req_o           = req_r;
  assign dbus_we_o            = we_r;
  assign dbus_wstrb_o         = wstrb_r;
  assign dbus_addr_o          = addr_r;
  assign dbus_wdata_o         = wdata_r;
  assign misalign_o           = misalign_r;
  assign wb_wR_o              = mem_wR_i;
  assign wb_debug_have_inst_o = mem_debug_wb_have_inst_i;
  assign wb_reg_we_o          = mem_reg_we_i & ~(is_load_s & misalign_s);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected bus requests and write-back
// results; a negedge monitor pops and compares. Timeout case runs only with MEM_TIMEOUT_EN.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TB_TMO = 4;
`else
  localparam int TB_TMO = 255;
`endif

  logic        clk;
  logic        rst;
  logic        pipeline_stop_i;
  logic [1:0]  mem_reg_write_i;
  logic [1:0]  mem_mem_write_i;
  logic        mem_mem_read_i;
  logic        mem_reg_we_i;
  logic [31:0] mem_resC_i;
  logic [31:0] mem_rD2_i;
  logic [31:0] mem_ext_i;
  logic [31:0] mem_pc4_i;
  logic [4:0]  mem_wR_i;
  logic        mem_debug_wb_have_inst_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [3:0]  dbus_wstrb_o;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_wdata_o;
  logic [31:0] dbus_rdata_i;
  logic        dbus_ack_i;
  logic        pipeline_stop_o;
  logic [31:0] wb_wd_o;
  logic [4:0]  wb_wR_o;
  logic        wb_reg_we_o;
  logic        wb_debug_have_inst_o;
  logic        misalign_o;
`ifdef MEM_TIMEOUT_EN
  logic        err_o;
`endif

  mem_access_ctrl #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .rst(rst), .pipeline_stop_i(pipeline_stop_i),
    .mem_reg_write_i(mem_reg_write_i), .mem_mem_write_i(mem_mem_write_i),
    .mem_mem_read_i(mem_mem_read_i), .mem_reg_we_i(mem_reg_we_i),
    .mem_resC_i(mem_resC_i), .mem_rD2_i(mem_rD2_i), .mem_ext_i(mem_ext_i),
    .mem_pc4_i(mem_pc4_i), .mem_wR_i(mem_wR_i),
    .mem_debug_wb_have_inst_i(mem_debug_wb_have_inst_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_wstrb_o(dbus_wstrb_o),
    .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
    .pipeline_stop_o(pipeline_stop_o), .wb_wd_o(wb_wd_o), .wb_wR_o(wb_wR_o),
    .wb_reg_we_o(wb_reg_we_o), .wb_debug_have_inst_o(wb_debug_have_inst_o),
`ifdef MEM_TIMEOUT_EN
    .err_o(err_o),
`endif
    .misalign_o(misalign_o)
  );

  typedef struct {
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] wd;
    logic        we;
  } wb_exp_t;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];

  int checks = 0;
  int failures = 0;
  int ack_lat = 0;
  int ack_cnt = 0;
  int req_rises = 0;
  int mis_pulses = 0;
  logic slave_ack = 1'b0;
  logic stray_ack = 1'b0;
  logic req_prev = 1'b0;

  assign dbus_ack_i = slave_ack | stray_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus slave: acks the ack_lat-th cycle of a request; ack_lat==0 never acks.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dbus_req_o && ack_lat > 0) begin
        ack_cnt++;
        slave_ack = (ack_cnt == ack_lat);
      end else begin
        ack_cnt = 0;
        slave_ack = 1'b0;
      end
    end
  end

  // Monitor: compares each new request and each completing instruction.
  initial begin
    bus_exp_t eb;
    wb_exp_t  ew;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_prev = 1'b0;
      end else begin
        if (misalign_o) mis_pulses++;
        if (dbus_req_o && !req_prev) begin
          req_rises++;
          checks++;
          if (bus_q.size() == 0) begin
            failures++;
            $display("FAIL bus_unexpected: got request addr %h expected none", dbus_addr_o);
          end else begin
            eb = bus_q.pop_front();
            chk("bus_we", {31'd0, dbus_we_o}, {31'd0, eb.we});
            chk("bus_strb", {28'd0, dbus_wstrb_o}, {28'd0, eb.strb});
            chk("bus_addr", dbus_addr_o, eb.addr);
            if (eb.chk_wdata) chk("bus_wdata", dbus_wdata_o, eb.wdata);
          end
        end
        req_prev = dbus_req_o;
        if ((mem_mem_read_i || mem_mem_write_i != 2'b00) && !pipeline_stop_o && !pipeline_stop_i) begin
          checks++;
          if (wb_q.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected: got completion wd %h expected none", wb_wd_o);
          end else begin
            ew = wb_q.pop_front();
            chk("wb_wd", wb_wd_o, ew.wd);
            chk("wb_reg_we", {31'd0, wb_reg_we_o}, {31'd0, ew.we});
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    mem_mem_write_i = 2'b00;
    mem_mem_read_i  = 1'b0;
    pipeline_stop_i = 1'b0;
  endtask

  task automatic run_access(input string nm, input logic [1:0] mw, input logic mr,
                            input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] rd2,
                            input logic [31:0] rdata, input int lat, input int hold,
                            input int exp_stall, input int exp_req, input bus_exp_t eb,
                            input logic [31:0] exp_wd, input logic exp_we);
    int stall = 0;
    int req0;
    int mis0;
    bit done = 0;
    req0 = req_rises;
    mis0 = mis_pulses;
    if (exp_req > 0) bus_q.push_back(eb);
    wb_q.push_back('{exp_wd, exp_we});
    @(posedge clk);
    #1;
    mem_mem_write_i = mw;
    mem_mem_read_i  = mr;
    mem_reg_write_i = rw;
    mem_resC_i      = addr;
    mem_rD2_i       = rd2;
    dbus_rdata_i    = rdata;
    mem_reg_we_i    = 1'b1;
    ack_lat         = lat;
    pipeline_stop_i = (hold > 0);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (pipeline_stop_o) stall++;
      else done = 1;
    end
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: got stall still high expected release", nm);
    end
    chk({nm, "_stall"}, stall, exp_stall);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({nm, "_hold_wd"}, wb_wd_o, exp_wd);
        chk({nm, "_hold_req"}, {31'd0, dbus_req_o}, 32'd0);
      end
      @(posedge clk);
      #1;
      pipeline_stop_i = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    @(posedge clk);
    #1;
    chk({nm, "_reqs"}, req_rises - req0, exp_req);
    chk({nm, "_mis"}, mis_pulses - mis0, (exp_req == 0) ? 1 : 0);
  endtask

  initial begin
    bus_exp_t nb;
    nb = '{1'b0, 4'b0000, 32'h0, 32'h0, 1'b0};
    rst = 1'b1;
    clear_inputs();
    mem_reg_write_i = 2'b01;
    mem_reg_we_i = 1'b1;
    mem_resC_i = 32'h0;
    mem_rD2_i = 32'h0;
    mem_ext_i = 32'h0000_0055;
    mem_pc4_i = 32'h0000_1004;
    mem_wR_i = 5'd7;
    mem_debug_wb_have_inst_i = 1'b1;
    dbus_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, dbus_req_o}, 32'd0);
    chk("rst_we", {31'd0, dbus_we_o}, 32'd0);
    chk("rst_strb", {28'd0, dbus_wstrb_o}, 32'd0);
    chk("rst_addr", dbus_addr_o, 32'd0);
    chk("rst_wdata", dbus_wdata_o, 32'd0);
    chk("rst_loadq", wb_wd_o, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    chk("rst_stop", {31'd0, pipeline_stop_o}, 32'd0);
    chk("pass_wR", {27'd0, wb_wR_o}, 32'd7);
    chk("pass_dbg", {31'd0, wb_debug_have_inst_o}, 32'd1);
`ifdef MEM_TIMEOUT_EN
    chk("rst_err", {31'd0, err_o}, 32'd0);
`endif

    run_access("sw100", 2'b01, 1'b0, 2'b00, 32'h100, 32'h1122_3344, 32'h0, 3, 0, 4, 1,
               '{1'b1, 4'b1111, 32'h100, 32'h1122_3344, 1'b1}, 32'h100, 1'b1);
    run_access("sb103", 2'b11, 1'b0, 2'b00, 32'h103, 32'h0000_00AB, 32'h0, 1, 0, 2, 1,
               '{1'b1, 4'b1000, 32'h100, 32'hABAB_ABAB, 1'b1}, 32'h103, 1'b1);
    run_access("sh102", 2'b10, 1'b0, 2'b00, 32'h102, 32'h1234_BEEF, 32'h0, 2, 0, 3, 1,
               '{1'b1, 4'b1100, 32'h100, 32'hBEEF_BEEF, 1'b1}, 32'h102, 1'b1);
    run_access("sh200", 2'b10, 1'b0, 2'b00, 32'h200, 32'h0000_5A5A, 32'h0, 1, 0, 2, 1,
               '{1'b1, 4'b0011, 32'h200, 32'h5A5A_5A5A, 1'b1}, 32'h200, 1'b1);
    run_access("sb201", 2'b11, 1'b0, 2'b11, 32'h201, 32'h0000_0077, 32'h0, 2, 0, 3, 1,
               '{1'b1, 4'b0010, 32'h200, 32'h7777_7777, 1'b1}, 32'h1004, 1'b1);
    run_access("lw40", 2'b00, 1'b1, 2'b01, 32'h40, 32'h0, 32'hCAFE_F00D, 1, 2, 2, 1,
               '{1'b0, 4'b0000, 32'h40, 32'h0, 1'b0}, 32'hCAFE_F00D, 1'b1);
    run_access("sw102", 2'b01, 1'b0, 2'b00, 32'h102, 32'h1, 32'h0, 1, 0, 0, 0, nb, 32'h102, 1'b1);
    run_access("lw101", 2'b00, 1'b1, 2'b01, 32'h101, 32'h0, 32'h0, 1, 0, 0, 0, nb, 32'hCAFE_F00D, 1'b0);
    run_access("sh103", 2'b10, 1'b0, 2'b10, 32'h103, 32'h0, 32'h0, 1, 0, 0, 0, nb, 32'h55, 1'b1);
    run_access("sb003", 2'b11, 1'b0, 2'b11, 32'h003, 32'hFFFF_FF12, 32'h0, 1, 0, 2, 1,
               '{1'b1, 4'b1000, 32'h0, 32'h1212_1212, 1'b1}, 32'h1004, 1'b1);
    run_access("lw44", 2'b00, 1'b1, 2'b01, 32'h44, 32'h0, 32'h0BAD_BEEF, 3, 0, 4, 1,
               '{1'b0, 4'b0000, 32'h44, 32'h0, 1'b0}, 32'h0BAD_BEEF, 1'b1);

    // Ack with no request outstanding must be ignored.
    mem_reg_write_i = 2'b01;
    stray_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_req", {31'd0, dbus_req_o}, 32'd0);
      chk("stray_stop", {31'd0, pipeline_stop_o}, 32'd0);
      chk("stray_loadq", wb_wd_o, 32'h0BAD_BEEF);
    end
    @(posedge clk);
    #1;
    stray_ack = 1'b0;

    // Reset while BUSY abandons the request.
    bus_q.push_back('{1'b1, 4'b1111, 32'h300, 32'hDEAD_BEEF, 1'b1});
    @(posedge clk);
    #1;
    mem_mem_write_i = 2'b01;
    mem_resC_i = 32'h300;
    mem_rD2_i = 32'hDEAD_BEEF;
    ack_lat = 0;
    repeat (3) @(negedge clk);
    chk("busy_req", {31'd0, dbus_req_o}, 32'd1);
    chk("busy_stop", {31'd0, pipeline_stop_o}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_inputs();
    mem_reg_write_i = 2'b01;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req", {31'd0, dbus_req_o}, 32'd0);
    chk("midrst_we", {31'd0, dbus_we_o}, 32'd0);
    chk("midrst_strb", {28'd0, dbus_wstrb_o}, 32'd0);
    chk("midrst_addr", dbus_addr_o, 32'd0);
    chk("midrst_wdata", dbus_wdata_o, 32'd0);
    chk("midrst_loadq", wb_wd_o, 32'd0);

    run_access("swlw80", 2'b01, 1'b1, 2'b00, 32'h80, 32'hA5A5_F00F, 32'h0, 1, 0, 2, 1,
               '{1'b1, 4'b1111, 32'h80, 32'hA5A5_F00F, 1'b1}, 32'h80, 1'b1);
    run_access("lw48", 2'b00, 1'b1, 2'b10, 32'h48, 32'h0, 32'h0000_0099, 2, 0, 3, 1,
               '{1'b0, 4'b0000, 32'h48, 32'h0, 1'b0}, 32'h55, 1'b1);
`ifdef MEM_TIMEOUT_EN
    run_access("lw4c_tmo", 2'b00, 1'b1, 2'b01, 32'h4C, 32'h0, 32'h1234_5678, 0, 0, 5, 1,
               '{1'b0, 4'b0000, 32'h4C, 32'h0, 1'b0}, 32'h0, 1'b1);
    chk("tmo_err", {31'd0, err_o}, 32'd1);
`endif

    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("wb_q_empty", wb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
